// File: rtl/x3q16_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : x3q16_mem_ctrl
// Purpose  : Memory controller behind the x3q16 core request port. Services
//            single-cycle read/write requests against an internal RAM of
//            16-bit words after a fixed, parameterised latency. A one-deep
//            pending slot absorbs a request that arrives while an access is
//            in flight. A host write port loads the program image.
// Ports    : clk, reset            - clock, async active-high reset
//            request, request_type - strobe, 0 = read / 1 = write
//            request_address       - core word address
//            data_out              - core write data
//            host_we/addr/data     - host program-load write port
//            memory_in             - read data (held until next read)
//            memory_ready          - one-cycle read-complete pulse
//            write_complete        - one-cycle write-complete pulse
//            memory_critical       - one-cycle out-of-range flag
//            busy                  - access in flight or pending
// Revision : 1.0 - initial release
// ============================================================================
module x3q16_mem_ctrl #(
   parameter int DEPTH_LOG2    = 12,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        request,
   input  logic        request_type,
   input  logic [15:0] request_address,
   input  logic [15:0] data_out,
   input  logic        host_we,
   input  logic [15:0] host_addr,
   input  logic [15:0] host_data,
   output logic [15:0] memory_in,
   output logic        memory_ready,
   output logic        write_complete,
   output logic        memory_critical,
   output logic        busy
);

   localparam int         c_DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [3:0] c_RD_LOAD = 4'(READ_LATENCY - 1);
   localparam logic [3:0] c_WR_LOAD = 4'(WRITE_LATENCY - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_type;
   logic [15:0] r_addr;
   logic [15:0] r_data;
   logic        r_pend_valid;
   logic        r_pend_type;
   logic [15:0] r_pend_addr;
   logic [15:0] r_pend_data;

   state_t      w_state_next;
   logic [3:0]  w_cnt_next;
   logic        w_type_next;
   logic [15:0] w_addr_next;
   logic [15:0] w_data_next;
   logic        w_pend_valid_next;
   logic        w_pend_type_next;
   logic [15:0] w_pend_addr_next;
   logic [15:0] w_pend_data_next;
   logic        w_busy_next;

   logic        w_respond;
   logic        w_in_range;
   logic        w_host_in_range;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [DEPTH_LOG2-1:0] w_host_idx;

   logic [15:0] ram [0:c_DEPTH-1];

   // The access is performed on the edge where the counter has run down.
   assign w_respond       = (r_state == ST_WAIT) && (r_cnt == 4'd0);
   assign w_in_range      = (r_addr >> DEPTH_LOG2) == 16'd0;
   assign w_host_in_range = (host_addr >> DEPTH_LOG2) == 16'd0;
   assign w_idx           = r_addr[DEPTH_LOG2-1:0];
   assign w_host_idx      = host_addr[DEPTH_LOG2-1:0];

   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt;
      w_type_next       = r_type;
      w_addr_next       = r_addr;
      w_data_next       = r_data;
      w_pend_valid_next = r_pend_valid;
      w_pend_type_next  = r_pend_type;
      w_pend_addr_next  = r_pend_addr;
      w_pend_data_next  = r_pend_data;

      case (r_state)
         ST_IDLE: begin
            if (r_pend_valid) begin
               // Pending request starts as if sampled now; a fresh request
               // on this same edge refills the slot being vacated.
               w_type_next       = r_pend_type;
               w_addr_next       = r_pend_addr;
               w_data_next       = r_pend_data;
               w_cnt_next        = r_pend_type ? c_WR_LOAD : c_RD_LOAD;
               w_state_next      = ST_WAIT;
               w_pend_valid_next = request;
               if (request) begin
                  w_pend_type_next = request_type;
                  w_pend_addr_next = request_address;
                  w_pend_data_next = data_out;
               end
            end else if (request) begin
               w_type_next  = request_type;
               w_addr_next  = request_address;
               w_data_next  = data_out;
               w_cnt_next   = request_type ? c_WR_LOAD : c_RD_LOAD;
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Only one request can wait; further ones are dropped.
            if (request && !r_pend_valid) begin
               w_pend_valid_next = 1'b1;
               w_pend_type_next  = request_type;
               w_pend_addr_next  = request_address;
               w_pend_data_next  = data_out;
            end
            if (r_cnt == 4'd0) begin
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      w_busy_next = (w_state_next != ST_IDLE) || w_pend_valid_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_cnt           <= 4'd0;
         r_type          <= 1'b0;
         r_addr          <= 16'd0;
         r_data          <= 16'd0;
         r_pend_valid    <= 1'b0;
         r_pend_type     <= 1'b0;
         r_pend_addr     <= 16'd0;
         r_pend_data     <= 16'd0;
         memory_in       <= 16'd0;
         memory_ready    <= 1'b0;
         write_complete  <= 1'b0;
         memory_critical <= 1'b0;
         busy            <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_cnt           <= w_cnt_next;
         r_type          <= w_type_next;
         r_addr          <= w_addr_next;
         r_data          <= w_data_next;
         r_pend_valid    <= w_pend_valid_next;
         r_pend_type     <= w_pend_type_next;
         r_pend_addr     <= w_pend_addr_next;
         r_pend_data     <= w_pend_data_next;
         memory_ready    <= w_respond && !r_type;
         write_complete  <= w_respond && r_type;
         memory_critical <= w_respond && !w_in_range;
         busy            <= w_busy_next;
         if (w_respond && !r_type) begin
            memory_in <= w_in_range ? ram[w_idx] : 16'h0000;
         end
      end
   end

   // RAM is not reset. The core write is placed after the host write so it
   // takes priority on an address collision; a same-edge core read sees the
   // pre-write contents because both updates are non-blocking.
   always_ff @(posedge clk) begin
      if (host_we && w_host_in_range) begin
         ram[w_host_idx] <= host_data;
      end
      if (w_respond && r_type && w_in_range) begin
         ram[w_idx] <= r_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_x3q16_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_x3q16_mem_ctrl
// Purpose  : Directed self-checking bench for x3q16_mem_ctrl. Instance dut
//            uses 2/2 read/write latency; instance dut_w1 uses write
//            latency 1 for the host/core collision case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x3q16_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        request = 1'b0;
   logic        request_type = 1'b0;
   logic [15:0] request_address = 16'd0;
   logic [15:0] data_out = 16'd0;
   logic        host_we = 1'b0;
   logic [15:0] host_addr = 16'd0;
   logic [15:0] host_data = 16'd0;
   logic [15:0] memory_in;
   logic        memory_ready;
   logic        write_complete;
   logic        memory_critical;
   logic        busy;

   logic        b_request = 1'b0;
   logic        b_request_type = 1'b0;
   logic [15:0] b_request_address = 16'd0;
   logic [15:0] b_data_out = 16'd0;
   logic        b_host_we = 1'b0;
   logic [15:0] b_host_addr = 16'd0;
   logic [15:0] b_host_data = 16'd0;
   logic [15:0] b_memory_in;
   logic        b_memory_ready;
   logic        b_write_complete;
   logic        b_memory_critical;
   logic        b_busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   x3q16_mem_ctrl #(
      .DEPTH_LOG2    (12),
      .READ_LATENCY  (2),
      .WRITE_LATENCY (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .request         (request),
      .request_type    (request_type),
      .request_address (request_address),
      .data_out        (data_out),
      .host_we         (host_we),
      .host_addr       (host_addr),
      .host_data       (host_data),
      .memory_in       (memory_in),
      .memory_ready    (memory_ready),
      .write_complete  (write_complete),
      .memory_critical (memory_critical),
      .busy            (busy)
   );

   x3q16_mem_ctrl #(
      .DEPTH_LOG2    (12),
      .READ_LATENCY  (2),
      .WRITE_LATENCY (1)
   ) dut_w1 (
      .clk             (clk),
      .reset           (reset),
      .request         (b_request),
      .request_type    (b_request_type),
      .request_address (b_request_address),
      .data_out        (b_data_out),
      .host_we         (b_host_we),
      .host_addr       (b_host_addr),
      .host_data       (b_host_data),
      .memory_in       (b_memory_in),
      .memory_ready    (b_memory_ready),
      .write_complete  (b_write_complete),
      .memory_critical (b_memory_critical),
      .busy            (b_busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic t, input logic [15:0] a, input logic [15:0] d);
      request         = 1'b1;
      request_type    = t;
      request_address = a;
      data_out        = d;
      tick();
      request         = 1'b0;
   endtask

   task automatic host_wr(input logic [15:0] a, input logic [15:0] d);
      host_we   = 1'b1;
      host_addr = a;
      host_data = d;
      tick();
      host_we   = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      reset = 1'b0;
      check("rst_mem_in", memory_in, 16'h0000);
      check("rst_ready", {15'd0, memory_ready}, 16'd0);
      check("rst_wc", {15'd0, write_complete}, 16'd0);
      check("rst_crit", {15'd0, memory_critical}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);

      // Program load
      host_wr(16'h0010, 16'hBEEF);
      host_wr(16'h0000, 16'h0A0A);
      host_wr(16'h0001, 16'h1111);
      host_wr(16'h0002, 16'h2222);
      host_wr(16'h0030, 16'h3030);
      host_wr(16'hF001, 16'h9999);   // out of range: ignored, no flag
      check("host_oor_crit", {15'd0, memory_critical}, 16'd0);

      // Read of host-loaded word, latency 2
      issue(1'b0, 16'h0010, 16'h0000);
      check("rd1_busy", {15'd0, busy}, 16'd1);
      check("rd1_ready_e0", {15'd0, memory_ready}, 16'd0);
      tick();
      check("rd1_ready_e1", {15'd0, memory_ready}, 16'd0);
      tick();
      check("rd1_ready", {15'd0, memory_ready}, 16'd1);
      check("rd1_data", memory_in, 16'hBEEF);
      check("rd1_crit", {15'd0, memory_critical}, 16'd0);
      check("rd1_busy_end", {15'd0, busy}, 16'd0);
      tick();
      check("rd1_ready_pulse", {15'd0, memory_ready}, 16'd0);

      // Core write then read back
      issue(1'b1, 16'h0020, 16'h1234);
      tick();
      check("wr2_wc_e1", {15'd0, write_complete}, 16'd0);
      tick();
      check("wr2_wc", {15'd0, write_complete}, 16'd1);
      check("wr2_crit", {15'd0, memory_critical}, 16'd0);
      check("wr2_mem_in_held", memory_in, 16'hBEEF);
      check("wr2_no_ready", {15'd0, memory_ready}, 16'd0);
      tick();
      check("wr2_wc_pulse", {15'd0, write_complete}, 16'd0);
      issue(1'b0, 16'h0020, 16'h0000);
      tick();
      tick();
      check("rd2_ready", {15'd0, memory_ready}, 16'd1);
      check("rd2_data", memory_in, 16'h1234);

      // Out-of-range read and write
      issue(1'b0, 16'hF000, 16'h0000);
      tick();
      tick();
      check("oor_rd_ready", {15'd0, memory_ready}, 16'd1);
      check("oor_rd_crit", {15'd0, memory_critical}, 16'd1);
      check("oor_rd_data", memory_in, 16'h0000);
      tick();
      check("oor_rd_crit_pulse", {15'd0, memory_critical}, 16'd0);
      issue(1'b1, 16'hF000, 16'h7777);
      tick();
      tick();
      check("oor_wr_wc", {15'd0, write_complete}, 16'd1);
      check("oor_wr_crit", {15'd0, memory_critical}, 16'd1);
      tick();
      issue(1'b0, 16'h0000, 16'h0000);
      tick();
      tick();
      check("oor_wr_ram_kept", memory_in, 16'h0A0A);
      tick();

      // Pending slot: second request queued, third dropped
      request = 1'b1; request_type = 1'b0; request_address = 16'h0000;
      tick();
      check("pend_busy0", {15'd0, busy}, 16'd1);
      request_address = 16'h0001;
      tick();
      check("pend_ready_e1", {15'd0, memory_ready}, 16'd0);
      request_address = 16'h0002;
      tick();
      request = 1'b0;
      check("pend_ready_a", {15'd0, memory_ready}, 16'd1);
      check("pend_data_a", memory_in, 16'h0A0A);
      check("pend_busy_a", {15'd0, busy}, 16'd1);
      tick();
      check("pend_gap", {15'd0, memory_ready}, 16'd0);
      check("pend_busy_gap", {15'd0, busy}, 16'd1);
      tick();
      check("pend_ready_e4", {15'd0, memory_ready}, 16'd0);
      tick();
      check("pend_ready_b", {15'd0, memory_ready}, 16'd1);
      check("pend_data_b", memory_in, 16'h1111);
      check("pend_busy_b", {15'd0, busy}, 16'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("pend_dropped", {15'd0, memory_ready}, 16'd0);
      end
      check("pend_data_final", memory_in, 16'h1111);

      // Reset during an in-flight write
      issue(1'b1, 16'h0030, 16'hDEAD);
      tick();
      reset = 1'b1;
      #1;
      check("arst_mem_in", memory_in, 16'h0000);
      check("arst_busy", {15'd0, busy}, 16'd0);
      check("arst_ready", {15'd0, memory_ready}, 16'd0);
      check("arst_crit", {15'd0, memory_critical}, 16'd0);
      tick();
      check("arst_wc", {15'd0, write_complete}, 16'd0);
      reset = 1'b0;
      tick();
      tick();
      check("arst_wc_after", {15'd0, write_complete}, 16'd0);
      check("arst_busy_after", {15'd0, busy}, 16'd0);
      issue(1'b0, 16'h0030, 16'h0000);
      tick();
      tick();
      check("arst_ram_kept", memory_in, 16'h3030);

      // Host/core write collision on the commit edge, write latency 1
      b_request = 1'b1; b_request_type = 1'b1;
      b_request_address = 16'h0040; b_data_out = 16'h5555;
      tick();
      b_request = 1'b0;
      b_host_we = 1'b1; b_host_addr = 16'h0040; b_host_data = 16'hAAAA;
      tick();
      b_host_we = 1'b0;
      check("w1_wc", {15'd0, b_write_complete}, 16'd1);
      tick();
      check("w1_wc_pulse", {15'd0, b_write_complete}, 16'd0);
      b_request = 1'b1; b_request_type = 1'b0; b_request_address = 16'h0040;
      tick();
      b_request = 1'b0;
      tick();
      tick();
      check("w1_ready", {15'd0, b_memory_ready}, 16'd1);
      check("w1_core_wins", b_memory_in, 16'h5555);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/x3q16_mem_ctrl.md
Name: x3q16_mem_ctrl

Overview:
- Memory controller directly downstream of the x3q16 core's memory request port.
- Accepts the core's single-cycle `request` pulse with address, type and write data, and services it against an internal 16-bit-word RAM after a fixed, parameterised latency.
- Returns `memory_ready` / `memory_in` for reads and `write_complete` for writes; flags out-of-range accesses on `memory_critical`.
- Provides a host program-load write port used to fill RAM before and while the core runs.

Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 16-bit words (4096 words).
- READ_LATENCY, 2, clock edges from request acceptance to `memory_ready` assertion; legal range 1..15.
- WRITE_LATENCY, 2, clock edges from request acceptance to `write_complete` assertion; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- request  input  1  core request strobe; sampled each rising edge.
- request_type  input  1  0 = read, 1 = write `data_out` to `request_address`.
- request_address  input  16  word address.
- data_out  input  16  core write data.
- host_we  input  1  host program-load write strobe.
- host_addr  input  16  host write address.
- host_data  input  16  host write data.
- memory_in  output  16  read data to core.
- memory_ready  output  1  one-cycle pulse: read data valid on `memory_in`.
- write_complete  output  1  one-cycle pulse: write committed.
- memory_critical  output  1  one-cycle pulse: the completing access was out of range.
- busy  output  1  high while a core access is pending or in flight.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0, state goes to IDLE, pending slot cleared, latency counter cleared.
  - RAM contents are not cleared.
  - Reset mid-access aborts the access: no `memory_ready` or `write_complete` is produced, and a write in flight is not committed.
- States:
  - IDLE: no access in flight. On a rising edge with `request` = 1:
    - latch type, address and data;
    - load the counter with LAT-1 (LAT = READ_LATENCY or WRITE_LATENCY per type);
    - go to WAIT.
  - WAIT: counter decrements each edge. On the edge where the counter is 0, perform the access, register the response outputs and go to IDLE.
  - Net latency: a request sampled at edge N yields its response pulse high in the cycle following edge N+LAT. With LAT = 1 that is the cycle following edge N+1.
- Read response:
  - `memory_in` is loaded with RAM[addr] at the response edge and holds until the next read completes. Writes and host writes do not change it.
  - `memory_ready` is high for exactly one cycle.
- Write response:
  - RAM[addr] <= latched data at the response edge.
  - `write_complete` is high for exactly one cycle.
  - `memory_in` is unchanged.
- Address range:
  - In range: addr < 2**DEPTH_LOG2. The RAM index is addr[DEPTH_LOG2-1:0].
  - Out of range: the read returns 16'h0000 and the write is discarded. The normal ready/complete pulse still fires, with `memory_critical` high in the same cycle.
- Host port:
  - When `host_we` = 1 and `host_addr` is in range, RAM[host_addr] <= host_data on that edge.
  - An out-of-range host write is ignored and does not raise `memory_critical`.
  - Host write and a core write to the same address on the same edge: the core write wins.
  - Host write and a core read of the same address on the same edge: the read returns the pre-write value.
- Request while not IDLE (including the response edge):
  - Captured into a one-deep pending slot.
  - Started on the edge after the current response completes, as if sampled on that edge.
  - A request arriving while the pending slot is already full is dropped.
- `busy` = (state != IDLE) | pending slot valid. It is registered alongside the state.
- Response pulses are never high in consecutive cycles for back-to-back accesses.

Test Plan:
- Host-write 16'hBEEF to addr 16'h0010, then core read 16'h0010 (READ_LATENCY = 2) -> `memory_ready` high for one cycle, two edges after acceptance, with `memory_in` = 16'hBEEF and `memory_critical` = 0.
- Core write 16'h1234 to 16'h0020, then read 16'h0020 -> `write_complete` pulses once after 2 edges; the read returns 16'h1234.
- Core read of 16'hF000 (out of range) -> `memory_in` = 16'h0000, with `memory_ready` and `memory_critical` high in the same single cycle. A write to 16'hF000 pulses `write_complete` + `memory_critical` and leaves RAM unchanged.
- Request on 16'h0001 while the read of 16'h0000 is in WAIT, plus a third request while pending -> two `memory_ready` pulses in address order, with the third request dropped; `busy` falls after the second response.
- Assert reset one edge after a write request to 16'h0030 -> no `write_complete`, RAM[16'h0030] unchanged, all outputs 0.
- Same-edge host write 16'hAAAA and core write 16'h5555 to 16'h0040 (WRITE_LATENCY = 1) -> a subsequent read returns 16'h5555.
